// File: rtl/fifo_uart_tx_drain.sv
// UART transmit drain: pops bytes from the FIFO and sends them 8N1, LSB first, timed by a 16x baud tick.
// Optional build macro UART_TX_PARITY_EN adds an even parity bit between the data bits and the stop bit.
module fifo_uart_tx_drain #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iBaudTick,
    input  logic              iEmpty,
    input  logic [DATA_W-1:0] iRdData,
    output logic              oPop,
    output logic              oTx,
    output logic              oBusy,
    output logic              oTxDone
);
    localparam int TICK_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic evenParity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t              state_r;
    state_t              nextState_s;
    logic [TICK_W-1:0]   tickCnt_r;
    logic [TICK_W-1:0]   tickNext_s;
    logic [BIT_W-1:0]    bitCnt_r;
    logic [BIT_W-1:0]    bitNext_s;
    logic [DATA_W-1:0]   shift_r;
    logic [DATA_W-1:0]   shiftNext_s;
    logic                bitEnd_s;
    logic                txNext_s;
    logic                popNext_s;
    logic                busyNext_s;
    logic                doneNext_s;
`ifdef UART_TX_PARITY_EN
    logic                parity_r;
`endif

    // A bit period ends on the baud tick that completes OVS ticks.
    assign bitEnd_s = iBaudTick && (tickCnt_r == TICK_LAST);

    // State register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state decode: one frame per pop, back to IDLE for exactly one cycle after STOP.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (!iEmpty) nextState_s = START;
                else         nextState_s = IDLE;
            end
            START: begin
                if (bitEnd_s) nextState_s = DATA;
                else          nextState_s = START;
            end
            DATA: begin
                if (bitEnd_s && (bitCnt_r == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    nextState_s = PARITY;
`else
                    nextState_s = STOP;
`endif
                end else begin
                    nextState_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd_s) nextState_s = STOP;
                else          nextState_s = PARITY;
            end
`endif
            STOP: begin
                if (bitEnd_s) nextState_s = IDLE;
                else          nextState_s = STOP;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // Datapath next values; ticks seen in IDLE never pre-advance the counter.
    always_comb begin
        tickNext_s  = tickCnt_r;
        bitNext_s   = bitCnt_r;
        shiftNext_s = shift_r;
        if (state_r == IDLE) begin
            tickNext_s = {TICK_W{1'b0}};
            bitNext_s  = {BIT_W{1'b0}};
            if (!iEmpty) shiftNext_s = iRdData;
            else         shiftNext_s = shift_r;
        end else if (iBaudTick) begin
            if (tickCnt_r == TICK_LAST) tickNext_s = {TICK_W{1'b0}};
            else                        tickNext_s = tickCnt_r + TICK_W'(1);
            if ((state_r == DATA) && (tickCnt_r == TICK_LAST)) begin
                shiftNext_s = {1'b0, shift_r[DATA_W-1:1]};
                bitNext_s   = bitCnt_r + BIT_W'(1);
            end else begin
                shiftNext_s = shift_r;
                bitNext_s   = bitCnt_r;
            end
        end else begin
            tickNext_s  = tickCnt_r;
        end
    end

    // Datapath registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            tickCnt_r <= {TICK_W{1'b0}};
            bitCnt_r  <= {BIT_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
        end else begin
            tickCnt_r <= tickNext_s;
            bitCnt_r  <= bitNext_s;
            shift_r   <= shiftNext_s;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured with the byte so it is ready when PARITY is entered.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            parity_r <= 1'b0;
        end else if ((state_r == IDLE) && !iEmpty) begin
            parity_r <= evenParity(iRdData);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // Output decode from the upcoming state so the registered outputs line up with state_r.
    always_comb begin
        popNext_s  = (state_r == IDLE) && !iEmpty;
        busyNext_s = (nextState_s != IDLE);
        doneNext_s = (state_r == STOP) && bitEnd_s;
        txNext_s   = 1'b1;
        case (nextState_s)
            IDLE:    txNext_s = 1'b1;
            START:   txNext_s = 1'b0;
            DATA:    txNext_s = shiftNext_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txNext_s = parity_r;
`endif
            STOP:    txNext_s = 1'b1;
            default: txNext_s = 1'b1;
        endcase
    end

    // Output registers; reset forces the line idle immediately.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oTx     <= 1'b1;
            oPop    <= 1'b0;
            oBusy   <= 1'b0;
            oTxDone <= 1'b0;
        end else begin
            oTx     <= txNext_s;
            oPop    <= popNext_s;
            oBusy   <= busyNext_s;
            oTxDone <= doneNext_s;
        end
    end
endmodule
